seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 5 +
 rtl/ripple_subtractor.sv | 13 +
 rtl/seq_divider.sv | 90 +++++++++
 tb/tb_seq_divider.sv | 117 +++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default width for the sequential divider.
package div_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    localparam int DEFAULT_WIDTH = 64;
endpackage

// File: rtl/ripple_subtractor.sv
// ripple_subtractor: a - b as a + ~b + 1; borrow is the inverted carry-out.
module ripple_subtractor #(
    parameter int W = 65
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);
    logic carry;
    assign {carry, diff} = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    assign borrow = ~carry;
endmodule

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per clock, MSB first.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH) + 1;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   pr;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   pr_next;
    logic [WIDTH-1:0] dvd_next;
    logic             borrow;
    // pr[WIDTH] is always clear after a step, so folding it into the shifted MSB changes nothing
    assign shifted  = {pr[WIDTH] | pr[WIDTH-1], pr[WIDTH-2:0], dvd[WIDTH-1]};
    assign pr_next  = borrow ? shifted : trial;
    assign dvd_next = {dvd[WIDTH-2:0], ~borrow};
    ripple_subtractor #(.W(WIDTH + 1)) u_sub (
        .a     (shifted),
        .b     ({1'b0, dsr}),
        .diff  (trial),
        .borrow(borrow)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            pr          <= '0;
            dvd         <= '0;
            dsr         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    dvd  <= dividend;
                    dsr  <= divisor;
                    pr   <= '0;
                    cnt  <= CW'(WIDTH);
                    busy <= 1'b1;
                    if (divisor == '0) begin
                        state       <= FIN;
                        done        <= 1'b1;
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end else begin
                        state       <= RUN;
                        div_by_zero <= 1'b0;
                    end
                end
                RUN: begin
                    pr  <= pr_next;
                    dvd <= dvd_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state     <= FIN;
                        done      <= 1'b1;
                        quotient  <= dvd_next;
                        remainder <= pr_next[WIDTH-1:0];
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider at WIDTH=64.
module tb_seq_divider;
    localparam int W = 64;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    int           n_vec = 0;
    int           n_err = 0;
    int           idx = 0;
    always #5 clk = ~clk;
    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step;
        @(negedge clk);
        idx++;
    endtask
    // called at a negedge while idle; start is accepted at the next rising edge
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        check("idle_busy", W'(busy), 0);
        check("idle_done", W'(done), 0);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx   = 1;
    endtask
    task automatic wait_done(input int lat, input logic [W-1:0] q, input logic [W-1:0] r,
                             input logic dz);
        while (!done && idx < 200) step;
        check("latency", W'(idx), W'(lat));
        check("done", W'(done), 1);
        check("busy_fin", W'(busy), 1);
        check("quotient", quotient, q);
        check("remainder", remainder, r);
        check("div_by_zero", W'(div_by_zero), W'(dz));
        step;
        check("done_pulse", W'(done), 0);
    endtask
    initial begin
        logic [W-1:0] a, b;
        repeat (3) @(negedge clk);
        check("rst_busy", W'(busy), 0);
        check("rst_done", W'(done), 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dz", W'(div_by_zero), 0);
        reset = 1'b0;
        @(negedge clk);
        launch(100, 7);
        wait_done(65, 14, 2, 1'b0);
        launch(5, 0);
        wait_done(1, 64'hFFFF_FFFF_FFFF_FFFF, 5, 1'b1);
        launch(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
        wait_done(65, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        launch(0, 9);
        wait_done(65, 0, 0, 1'b0);
        launch(64'hFFFF_FFFF_FFFF_FFFF, 1);
        wait_done(65, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
        launch(6, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done(65, 0, 6, 1'b0);
        launch(123, 10);
        while (idx < 20) step;
        dividend = 9;
        divisor  = 3;
        start    = 1'b1;
        step;
        start = 1'b0;
        wait_done(65, 12, 3, 1'b0);
        launch(1000, 3);
        while (idx < 30) step;
        reset = 1'b1;
        #1;
        check("abort_busy", W'(busy), 0);
        check("abort_done", W'(done), 0);
        check("abort_q", quotient, 0);
        check("abort_r", remainder, 0);
        check("abort_dz", W'(div_by_zero), 0);
        repeat (2) begin
            step;
            check("abort_nodone", W'(done), 0);
        end
        reset = 1'b0;
        repeat (70) begin
            step;
            check("post_rst_nodone", W'(done), 0);
        end
        launch(1000, 3);
        wait_done(65, 333, 1, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (b == 0) b = 1;
            launch(a, b);
            wait_done(65, a / b, a % b, 1'b0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
